// File: rtl/sequential_subtractor_64bit.sv
// Multi-cycle subtractor: diff = a - b - bin, one CHUNK-bit slice per clock, LSB slice first,
// borrow rippled between slices through a carry register; start/done handshake.
module sequential_subtractor_64bit #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s;
    logic             c;
    logic             accept;
    logic             last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        accept     = start && (state != RUN);
        last       = (state == RUN) && (cnt == CNT_W'(NSLICE - 1));
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction as a + ~b + carry, with carry seeded by ~bin; final carry = ~borrow.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
        {c, s} = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, carry};
        diff_next = diff_q;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (cnt == CNT_W'(i)) diff_next[i*CHUNK +: CHUNK] = s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            diff_q <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b1;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~bin;
            cnt   <= '0;
        end else if (state == RUN) begin
            diff_q <= diff_next;
            carry  <= c;
            cnt    <= cnt + 1'b1;
            if (last) begin
                bout_q <= ~c;
                ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_next[WIDTH-1] != a_q[WIDTH-1]);
                zero_q <= (diff_next == '0);
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_sequential_subtractor_64bit.sv
// Scoreboard bench for sequential_subtractor_64bit: expected results queued at issue time,
// popped and compared by a monitor whenever done is seen.
module tb_sequential_subtractor_64bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        bin = 1'b0;
    logic        busy, done, bout, ovf, zero;
    logic [63:0] diff;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    sequential_subtractor_64bit #(.WIDTH(64), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operand values.
    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mbin,
                                   input int when);
        exp_t        e;
        logic [64:0] w;
        w      = {1'b0, ma} - {1'b0, mb} - {64'd0, mbin};
        e.diff = w[63:0];
        e.bout = w[64];
        e.ovf  = (ma[63] != mb[63]) && (e.diff[63] != ma[63]);
        e.zero = (e.diff == 64'd0);
        e.cyc  = when;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", diff, e.diff);
                check("bout", {63'd0, bout}, {63'd0, e.bout});
                check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                check("zero", {63'd0, zero}, {63'd0, e.zero});
                check("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; accept edge is the next posedge, done seen 9 negedges-worth of cyc later.
    task automatic launch(input logic [63:0] la, input logic [63:0] lb, input logic lbin);
        a     = la;
        b     = lb;
        bin   = lbin;
        start = 1'b1;
        sb.push_back(model(la, lb, lbin, cyc + 9));
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = {$urandom, $urandom};
        b     = {$urandom, $urandom};
        bin   = 1'($urandom);
    endtask

    task automatic wait_done(input int exp_busy);
        int n    = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n++;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("busy_cycles", 64'(n), 64'(exp_busy));
    endtask

    task automatic run_op(input logic [63:0] ra, input logic [63:0] rb, input logic rbin);
        @(negedge clk);
        launch(ra, rb, rbin);
        wait_done(8);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_bout", {63'd0, bout}, 64'd0);
        check("rst_ovf", {63'd0, ovf}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        run_op(64'h10, 64'h1, 1'b0);
        run_op(64'h0, 64'h1, 1'b0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        run_op(64'h8000_0000_0000_0000, 64'h1, 1'b0);
        run_op(64'd5, 64'd3, 1'b1);
        run_op(64'd3, 64'd3, 1'b1);
        run_op(64'h0000_0001_0000_0000, 64'h1, 1'b0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Start during RUN cycle 3 must be ignored.
        @(negedge clk);
        launch(64'hDEAD_BEEF_0000_1111, 64'h0123_4567_89AB_CDEF, 1'b0);
        repeat (3) @(negedge clk);
        a = 64'hFFFF; b = 64'h1; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(5);

        // Back-to-back: second start in the DONE cycle.
        @(negedge clk);
        launch(64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAA, 1'b1);
        wait_done(8);
        launch(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0);
        wait_done(8);

        // Asynchronous reset in RUN cycle 4, between edges.
        @(negedge clk);
        launch(64'h1111_2222_3333_4444, 64'h0000_0000_0000_0005, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        run_op(64'h0000_0000_0001_0000, 64'h0000_0000_0000_0002, 1'b1);

        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: ra = 64'($urandom_range(0, 15));
                2: rb = {rb[63], ra[62:0]};
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom));
        end

        repeat (3) @(negedge clk);
        check("pending_results", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequential_subtractor_64bit.md
Name: sequential_subtractor_64bit

Overview:
- Multi-cycle 64-bit subtractor with a borrow chain: computes diff = a − b − bin.
- Processes one CHUNK-bit slice per clock, least-significant slice first, with the carry/borrow rippling between slices through a register.
- Serves as the inverse-operation companion to the combinational ripple adders in the ALU datapath.
- Trades latency for area and uses a start/done handshake so a controller FSM can sequence it.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NSLICE = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on a rising edge when not busy.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- bin  input  1  borrow-in; captured on the accepted start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; diff/bout/ovf/zero valid from this cycle.
- diff  output  WIDTH  a − b − bin modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 iff the unsigned value a < b + bin.
- ovf  output  1  two's-complement overflow of the signed subtraction.
- zero  output  1  diff == 0.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. While rst_n = 0:
  - state = IDLE.
  - busy = done = bout = ovf = 0; zero = 1; diff = 0.
  - Operand registers, slice counter and carry register cleared.
- Reset mid-operation aborts immediately; no done pulse is produced for the aborted operation.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start = 1 at edge k captures a, b, bin. Carry register ← ~bin, slice counter ← 0, state → RUN, busy = 1 from edge k.
  - RUN: each edge processes slice i = counter.
    - {c, s} = a[i] + ~b[i] + carry, where each term is CHUNK bits wide.
    - diff[i] ← s; carry ← c; counter++.
    - On the edge that processes slice NSLICE−1: state → DONE, busy → 0, done → 1.
  - DONE: lasts exactly one cycle with done = 1, then returns to IDLE (done → 0).
    - start = 1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations with no gap cycle.
- Latency: start sampled at edge k; done is high in the cycle following edge k+NSLICE (NSLICE = 8 with defaults).
- Start while busy (RUN) is ignored: no capture, no queuing, and the current operation is unaffected.
- Operand inputs may change freely after the accepted start; only the captured copies are used.
- Flags, updated on the final slice edge:
  - bout = ~final carry.
  - ovf = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the captured operands.
  - zero = (diff == 0).
- Output hold: diff, bout, ovf and zero hold their values after done until the last-slice edge of the next operation.
  - Lower slices of diff update progressively during RUN; consumers must sample only on done.
- Arithmetic is pure modular; there is no saturation. bin = 1 with a = b yields all-ones and bout = 1.

Test Plan:
- Basic: reset, then a = 0x10, b = 0x1, bin = 0, pulse start -> done exactly 8 cycles after the start edge; diff = 0xF, bout = 0, ovf = 0, zero = 0; busy high for 8 cycles.
- Unsigned underflow: a = 0, b = 1 -> diff = 0xFFFF_FFFF_FFFF_FFFF, bout = 1, ovf = 0. Also a = b = 0x1234_5678_9ABC_DEF0 -> diff = 0, zero = 1, bout = 0.
- Signed overflow and borrow-in:
  - a = 0x8000_0000_0000_0000, b = 1 -> diff = 0x7FFF_FFFF_FFFF_FFFF, ovf = 1, bout = 0.
  - a = 5, b = 3, bin = 1 -> diff = 1.
  - a = 3, b = 3, bin = 1 -> diff = all-ones, bout = 1.
- Cross-slice borrow: a = 0x0000_0001_0000_0000, b = 0x0000_0000_0000_0001 -> diff = 0x0000_0000_FFFF_FFFF, verifying the borrow propagates through four slices.
- Handshake:
  - start pulsed in cycle 3 of RUN with different operands -> ignored; the first result is unchanged.
  - start held high in the DONE cycle -> the second operation begins with no idle cycle; its done follows 8 cycles later.
- Reset mid-operation: rst_n driven low asynchronously (between clock edges) in cycle 4 of RUN -> outputs return to reset values immediately, no done pulse follows; the next start after release produces a correct result.
